// File: rtl/gapu_csd_pkg.sv
// Shared types and sizing for the Clifford systolic-array job sequencer.
// Holds the FSM state enum, the array geometry and the drain timeout.
package gapu_csd_pkg;

  localparam int GA_DIM      = 32;
  localparam int BLADE_W     = 5;
  localparam int CSD_TIMEOUT = 96;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FEED,
    S_DRAIN,
    S_RESP
  } csd_state_e;

endpackage

// File: rtl/csd_stream_rd.sv
// Base+count SRAM read generator shared by the V and Q streams.
// Ports: en/sel_q/base in; rd_en/rd_addr/last out; stb_v/stb_q/idx_d lag reads by one cycle.
module csd_stream_rd
  import gapu_csd_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               sel_q,
  input  logic [ADDR_W-1:0]  base,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic               last,
  output logic               stb_v,
  output logic               stb_q,
  output logic [BLADE_W-1:0] idx_d
);

  logic [BLADE_W-1:0] cnt;

  assign rd_en   = en;
  assign rd_addr = base + ADDR_W'(cnt);
  assign last    = en && (cnt == BLADE_W'(GA_DIM - 1));

  // cnt wraps to 0 after the last issue, so
  // FEED starts clean right after LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      stb_v <= 1'b0;
      stb_q <= 1'b0;
      idx_d <= '0;
    end else begin
      cnt   <= en ? cnt + 1'b1 : '0;
      stb_v <= en & ~sel_q;
      stb_q <= en & sel_q;
      idx_d <= cnt;
    end
  end

endmodule

// File: rtl/csd_seq_ctrl.sv
// Score-job sequencer: cmd handshake, V/Q streaming, drain with timeout, result port.
// Ports: cmd_*, mem_rd_*, arr_*, res_*, busy.
module csd_seq_ctrl
  import gapu_csd_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = CSD_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ADDR_W-1:0]  cmd_base_v,
  input  logic [ADDR_W-1:0]  cmd_base_q,
  input  logic               cmd_reuse_v,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_rd_addr,
  input  logic [31:0]        mem_rd_data,
  output logic               arr_load_weights,
  output logic [BLADE_W-1:0] arr_v_idx,
  output logic [31:0]        arr_v_data,
  output logic               arr_run_compute,
  output logic [31:0]        arr_q_data,
  input  logic               arr_valid_out,
  input  logic [31:0]        arr_score,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [31:0]        res_score,
  output logic               res_err,
  output logic               busy
);

  localparam int TMR_W = $clog2(TIMEOUT);

  csd_state_e         state, state_nx;
  logic [ADDR_W-1:0]  base_v, base_q, rd_base;
  logic               weights_ok;
  logic [TMR_W-1:0]   tmr;
  logic [31:0]        score_q;
  logic               err_q;
  logic               streaming, sel_q, rd_last;
  logic               stb_v, stb_q;
  logic [BLADE_W-1:0] idx_d;
  logic               expired;

  assign streaming = (state == S_LOAD) || (state == S_FEED);
  assign sel_q     = (state == S_FEED);
  assign rd_base   = sel_q ? base_q : base_v;
  assign expired   = (state == S_DRAIN) &&
                     (tmr == TMR_W'(TIMEOUT - 1));

  csd_stream_rd #(.ADDR_W(ADDR_W)) u_rd (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (streaming),
    .sel_q   (sel_q),
    .base    (rd_base),
    .rd_en   (mem_rd_en),
    .rd_addr (mem_rd_addr),
    .last    (rd_last),
    .stb_v   (stb_v),
    .stb_q   (stb_q),
    .idx_d   (idx_d)
  );

  assign arr_load_weights = stb_v;
  assign arr_v_idx        = stb_v ? idx_d : '0;
  assign arr_v_data       = stb_v ? mem_rd_data : '0;
  assign arr_run_compute  = stb_q;
  assign arr_q_data       = stb_q ? mem_rd_data : '0;
  assign res_score        = score_q;
  assign res_err          = err_q;

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid)
          state_nx = (cmd_reuse_v && weights_ok)
                     ? S_FEED : S_LOAD;
      end
      S_LOAD:
        if (rd_last) state_nx = S_FEED;
      S_FEED:
        if (rd_last) state_nx = S_DRAIN;
      S_DRAIN:
        if (arr_valid_out || expired)
          state_nx = S_RESP;
      S_RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      base_v     <= '0;
      base_q     <= '0;
      weights_ok <= 1'b0;
      tmr        <= '0;
      score_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nx;
      tmr   <= (state == S_DRAIN) ? tmr + 1'b1 : '0;
      if (state == S_IDLE && cmd_valid) begin
        base_v <= cmd_base_v;
        base_q <= cmd_base_q;
      end
      if (state == S_LOAD && rd_last)
        weights_ok <= 1'b1;
      else if (expired && !arr_valid_out)
        weights_ok <= 1'b0;
      // A result arriving on the timeout cycle still counts.
      if (state == S_DRAIN) begin
        if (arr_valid_out) begin
          score_q <= arr_score;
          err_q   <= 1'b0;
        end else if (expired) begin
          score_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_csd_seq_ctrl.sv
// Self-checking bench for csd_seq_ctrl: schedule-based model, SRAM and array models.
// Drives directed and randomized jobs and compares every output each cycle.
module tb_csd_seq_ctrl;
  import gapu_csd_pkg::*;

  localparam int AW = 12;
  localparam int TO = 96;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base_v = '0;
  logic [AW-1:0] cmd_base_q = '0;
  logic          cmd_reuse_v = 1'b0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [31:0]   mem_rd_data = '0;
  logic          arr_load_weights;
  logic [BLADE_W-1:0] arr_v_idx;
  logic [31:0]   arr_v_data;
  logic          arr_run_compute;
  logic [31:0]   arr_q_data;
  logic          arr_valid_out = 1'b0;
  logic [31:0]   arr_score = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [31:0]   res_score;
  logic          res_err;
  logic          busy;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] salt = '0;
  bit          wok = 1'b0;

  always #5 clk = ~clk;

  csd_seq_ctrl #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_base_v       (cmd_base_v),
    .cmd_base_q       (cmd_base_q),
    .cmd_reuse_v      (cmd_reuse_v),
    .mem_rd_en        (mem_rd_en),
    .mem_rd_addr      (mem_rd_addr),
    .mem_rd_data      (mem_rd_data),
    .arr_load_weights (arr_load_weights),
    .arr_v_idx        (arr_v_idx),
    .arr_v_data       (arr_v_data),
    .arr_run_compute  (arr_run_compute),
    .arr_q_data       (arr_q_data),
    .arr_valid_out    (arr_valid_out),
    .arr_score        (arr_score),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_score        (res_score),
    .res_err          (res_err),
    .busy             (busy)
  );

  function automatic logic [31:0] word(input logic [AW-1:0] a);
    return {20'h0, a} ^ salt;
  endfunction

  always @(posedge clk)
    mem_rd_data <= mem_rd_en ? word(mem_rd_addr) : 32'hDEADBEEF;

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s k=%0d got=%h want=%h", nm, k, act, exp);
    end
  endtask

  task automatic check_idle(input int k);
    chk("idle_cmd_ready", k, 32'(cmd_ready), 32'd1);
    chk("idle_busy", k, 32'(busy), 32'd0);
    chk("idle_rd_en", k, 32'(mem_rd_en), 32'd0);
    chk("idle_load_w", k, 32'(arr_load_weights), 32'd0);
    chk("idle_run_c", k, 32'(arr_run_compute), 32'd0);
    chk("idle_res_valid", k, 32'(res_valid), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cmd_valid     = 1'b0;
      cmd_base_v    = AW'($urandom);
      cmd_base_q    = AW'($urandom);
      cmd_reuse_v   = 1'($urandom);
      arr_valid_out = ($urandom_range(0, 3) == 0);
      arr_score     = $urandom;
      res_ready     = 1'($urandom);
      @(negedge clk);
      check_idle(-1 - i);
      @(posedge clk);
      #1;
    end
  endtask

  // One job, cycle k = 0 is the accept cycle. Expected outputs come from
  // the phase schedule: LOAD (P cycles), FEED (32), DRAIN (lat+1 or TO), RESP.
  task automatic run_job(input logic [AW-1:0] bv, input logic [AW-1:0] bq,
                         input bit reuse, input int lat,
                         input logic [31:0] sc, input int hold,
                         input int rst_at, input int pin,
                         input logic [31:0] slt);
    bit          load, ee;
    int          P, D, R, last;
    logic [31:0] es;
    salt = slt;
    load = !(reuse && wok);
    P    = load ? GA_DIM : 0;
    D    = P + GA_DIM + 1;
    if (lat < TO) begin
      R = D + lat + 1; es = sc; ee = 1'b0;
    end else begin
      R = D + TO; es = '0; ee = 1'b1;
    end
    last = R + hold;
    for (int k = 0; k <= last; k++) begin
      bit            e_rd, e_lw, e_rc, e_rv;
      logic [AW-1:0] ea;
      cmd_valid   = (k == 0) ? 1'b1 : 1'($urandom);
      cmd_base_v  = (k == 0) ? bv : AW'($urandom);
      cmd_base_q  = (k == 0) ? bq : AW'($urandom);
      cmd_reuse_v = (k == 0) ? reuse : 1'($urandom);
      if (lat < TO && k == D + lat) begin
        arr_valid_out = 1'b1; arr_score = sc;
      end else if (k < D || k >= R) begin
        arr_valid_out = ($urandom_range(0, 3) == 0);
        arr_score = $urandom;
      end else begin
        arr_valid_out = 1'b0; arr_score = $urandom;
      end
      res_ready = (k >= R) ? (k == last) : 1'($urandom);
      if (k == rst_at) begin
        #2 rst_n = 1'b0;
        #1 check_idle(k);
        chk("rst_v_idx", k, 32'(arr_v_idx), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wok = 1'b0;
        return;
      end
      @(negedge clk);
      e_rd = (k >= 1) && (k <= P + GA_DIM);
      e_lw = load && (k >= 2) && (k <= P + 1);
      e_rc = (k >= P + 2) && (k <= P + GA_DIM + 1);
      e_rv = (k >= R);
      ea   = (k <= P) ? bv + AW'(k - 1) : bq + AW'(k - P - 1);
      chk("cmd_ready", k, 32'(cmd_ready), 32'(k == 0));
      chk("busy", k, 32'(busy), 32'(k != 0));
      chk("mem_rd_en", k, 32'(mem_rd_en), 32'(e_rd));
      if (e_rd) chk("mem_rd_addr", k, 32'(mem_rd_addr), 32'(ea));
      chk("arr_load_weights", k, 32'(arr_load_weights), 32'(e_lw));
      if (e_lw) begin
        chk("arr_v_idx", k, 32'(arr_v_idx), 32'(k - 2));
        chk("arr_v_data", k, arr_v_data, word(bv + AW'(k - 2)));
      end
      chk("arr_run_compute", k, 32'(arr_run_compute), 32'(e_rc));
      if (e_rc) chk("arr_q_data", k, arr_q_data, word(bq + AW'(k - P - 2)));
      chk("res_valid", k, 32'(res_valid), 32'(e_rv));
      if (e_rv) begin
        chk("res_score", k, res_score, es);
        chk("res_err", k, 32'(res_err), 32'(ee));
      end
      case (pin)
        1: begin
          if (k == 2)  chk("pin_v_first", k, arr_v_data, 32'h100);
          if (k == 33) chk("pin_v_last", k, arr_v_data, 32'h11F);
          if (k == 33) chk("pin_idx_last", k, 32'(arr_v_idx), 32'd31);
          if (k == 34) chk("pin_q_first", k, arr_q_data, 32'h200);
          if (k == 65) chk("pin_q_last", k, arr_q_data, 32'h21F);
          if (k == 85) chk("pin_res_early", k, 32'(res_valid), 32'd0);
          if (k == 86) chk("pin_score", k, res_score, 32'h3F800000);
        end
        2: begin
          if (k == 1) chk("pin_reuse_addr", k, 32'(mem_rd_addr), 32'h300);
          if (k == 2) chk("pin_reuse_q", k, arr_q_data, 32'h300);
        end
        3: begin
          if (k == 160) chk("pin_to_early", k, 32'(res_valid), 32'd0);
          if (k == 161) chk("pin_to_err", k, 32'(res_err), 32'd1);
          if (k == 161) chk("pin_to_score", k, res_score, 32'd0);
        end
        4: if (k == 2) chk("pin_forced_load", k, 32'(arr_load_weights), 32'd1);
        5: begin
          if (k == 16) chk("pin_wrap_hi", k, 32'(mem_rd_addr), 32'hFFF);
          if (k == 17) chk("pin_wrap_lo", k, 32'(mem_rd_addr), 32'h000);
        end
        default: ;
      endcase
      @(posedge clk);
      #1;
    end
    if (load) wok = 1'b1;
    if (ee) wok = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) begin
      @(negedge clk);
      check_idle(-100);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(10);
    run_job(12'h100, 12'h200, 1'b0, 20, 32'h3F800000, 2, -1, 1, 32'h0);
    idle(1);
    run_job(12'h100, 12'h300, 1'b1, 10, 32'h12345678, 0, -1, 2, 32'h0);
    run_job(12'h040, 12'h080, 1'b0, 200, 32'h55AA55AA, 1, -1, 3, 32'h0);
    idle(2);
    run_job(12'h100, 12'h200, 1'b1, 5, 32'hCAFEF00D, 0, -1, 4, 32'h0);
    run_job(12'h010, 12'h020, 1'b1, 30, 32'h0BADC0DE, 50, -1, 0, 32'h1234_0000);
    run_job(12'h0A0, 12'h0B0, 1'b1, 95, 32'hFEEDFACE, 1, -1, 0, 32'h0);
    run_job(12'h0A0, 12'h0B0, 1'b1, 96, 32'hFEEDFACE, 1, -1, 0, 32'h0);
    run_job(12'h0C0, 12'h0D0, 1'b0, 0, 32'h00000001, 0, -1, 0, 32'h0);
    run_job(12'hFF0, 12'hFFE, 1'b0, 10, 32'h1, 0, GA_DIM + 10, 5, 32'h0);
    idle(3);
    run_job(12'h300, 12'h400, 1'b1, 3, 32'h77, 0, -1, 4, 32'h0);
    for (int j = 0; j < 30; j++) begin
      int lat;
      lat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(96, 120))
                                        : int'($urandom_range(0, 95));
      run_job(AW'($urandom), AW'($urandom), 1'($urandom), lat,
              $urandom, int'($urandom_range(0, 4)), -1, 0, $urandom);
      idle(int'($urandom_range(0, 2)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
